// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] MMIO_ADDR = 32'hf0000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } lsuState_t;

  // Size 2'b11 behaves as a word, so bit 1 alone marks word accesses.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] alignLo(input logic [1:0] size, input logic [1:0] lo);
    if (size[1])
      return 2'b00;
    else if (size == SZ_HALF)
      return {lo[1], 1'b0};
    else
      return lo;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic [31:0] mergeData
);

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  always_comb begin
    loadByte = word[{addrLo, 3'b000} +: 8];
    loadHalf = addrLo[1] ? word[31:16] : word[15:0];
    loadData = word;
    if (size == SZ_BYTE)
      loadData = {{24{sext & loadByte[7]}}, loadByte};
    else if (size == SZ_HALF)
      loadData = {{16{sext & loadHalf[15]}}, loadHalf};
  end

  // Each byte lane is either replaced from the store data or kept from the old word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;

      assign hit = size[1]
                 | ((size == SZ_HALF) && (addrLo[1] == LANE[1]))
                 | ((size == SZ_BYTE) && (addrLo == LANE));
      assign src = size[1] ? wdata[8*gi +: 8]
                 : (size == SZ_HALF) ? wdata[8*(gi%2) +: 8]
                 : wdata[7:0];
      assign mergeData[8*gi +: 8] = hit ? src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller driving the word-indexed data memory port.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] MmioAddr = MMIO_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] DataAdr,
  output logic [31:0] DataIn,
  output logic        DMemW,
  input  logic [31:0] DataOut
);

  lsuState_t   state;
  logic [1:0]  laneAddr;
  logic [1:0]  sizeReg;
  logic        signedReg;
  logic        weReg;
  logic [31:0] wdataReg;
  logic [31:0] loadData;
  logic [31:0] mergeData;
  logic        trapReq;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trapReq = isMisaligned(req_size, req_addr[1:0]);
`else
  assign trapReq = 1'b0;
`endif

  assign req_ready = (state == ST_IDLE);

  lsu_lane_align uAlign (
    .addrLo    (laneAddr),
    .size      (sizeReg),
    .sext      (signedReg),
    .word      (DataOut),
    .wdata     (wdataReg),
    .loadData  (loadData),
    .mergeData (mergeData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      laneAddr   <= 2'b00;
      sizeReg    <= SZ_BYTE;
      signedReg  <= 1'b0;
      weReg      <= 1'b0;
      wdataReg   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      DataAdr    <= '0;
      DataIn     <= '0;
      DMemW      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            laneAddr  <= alignLo(req_size, req_addr[1:0]);
            sizeReg   <= req_size;
            signedReg <= req_signed;
            weReg     <= req_we;
            wdataReg  <= req_wdata;
            // The status word is addressed by its raw byte address.
            DataAdr   <= (req_addr == MmioAddr) ? req_addr : {2'b00, req_addr[31:2]};
            if (trapReq) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && req_size[1]) begin
              state  <= ST_WRITE;
              DataIn <= req_wdata;
              DMemW  <= 1'b1;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (weReg) begin
            DataIn <= mergeData;
            DMemW  <= 1'b1;
            state  <= ST_WRITE;
          end else begin
            resp_rdata <= loadData;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          DMemW      <= 1'b0;
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
